// File: rtl/branch_predict_unit_if.sv
// Fetch/execute-side signal bundle for the branch predict unit.
// The master side drives the pipeline inputs; the slave side is the predictor.
interface branch_predict_unit_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] f_pc;
  logic            pred_taken;
  logic            e_valid;
  logic [XLEN-1:0] e_pc;
  logic [6:0]      opcode_e;
  logic [2:0]      fun3_e;
  logic [XLEN-1:0] fwd_a;
  logic [XLEN-1:0] fwd_b;
  logic            e_pred_taken;
  logic            intr;
  logic [1:0]      redirect;
  logic            redir_seq;
  logic [31:0]     br_cnt;
  logic [31:0]     mis_cnt;

  modport master (
    output f_pc, e_valid, e_pc, opcode_e, fun3_e, fwd_a, fwd_b, e_pred_taken, intr,
    input  pred_taken, redirect, redir_seq, br_cnt, mis_cnt
  );

  modport slave (
    input  f_pc, e_valid, e_pc, opcode_e, fun3_e, fwd_a, fwd_b, e_pred_taken, intr,
    output pred_taken, redirect, redir_seq, br_cnt, mis_cnt
  );
endinterface

// File: rtl/branch_predict_unit.sv
// Bimodal 2-bit branch predictor with execute-stage resolution, redirect
// generation (trap > branch mispredict > jump) and saturating statistics.
module branch_predict_unit #(
  parameter int          XLEN      = 32,
  parameter int          BHT_DEPTH = 64,
  parameter logic [1:0]  CTR_INIT  = 2'b01
) (
  input  logic                  clk,
  input  logic                  rst,
  branch_predict_unit_if.slave  bus
);

  localparam int         IDX_W     = $clog2(BHT_DEPTH);
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  logic [1:0]       bht [BHT_DEPTH];
  logic [IDX_W-1:0] f_idx;
  logic [IDX_W-1:0] e_idx;
  logic             actual;
  logic             upd;
  logic             mispred;
  logic [1:0]       redirect;
  logic             redir_seq;
  logic [31:0]      br_cnt_q;
  logic [31:0]      mis_cnt_q;
  logic             unused_pc_bits;

  assign f_idx = bus.f_pc[IDX_W+1:2];
  assign e_idx = bus.e_pc[IDX_W+1:2];
  assign unused_pc_bits = ^{bus.f_pc[XLEN-1:IDX_W+2], bus.f_pc[1:0],
                            bus.e_pc[XLEN-1:IDX_W+2], bus.e_pc[1:0]};

  // Lookup reads the stored value only, so a same-cycle update is not bypassed.
  assign bus.pred_taken = bht[f_idx][1];

  always_comb begin
    actual = 1'b0;
    case (bus.fun3_e)
      3'b000:  actual = (bus.fwd_a == bus.fwd_b);
      3'b001:  actual = (bus.fwd_a != bus.fwd_b);
      3'b100:  actual = ($signed(bus.fwd_a) <  $signed(bus.fwd_b));
      3'b101:  actual = ($signed(bus.fwd_a) >= $signed(bus.fwd_b));
      3'b110:  actual = (bus.fwd_a <  bus.fwd_b);
      3'b111:  actual = (bus.fwd_a >= bus.fwd_b);
      default: actual = 1'b0;
    endcase
  end

  always_comb begin
    redirect  = 2'b00;
    redir_seq = 1'b0;
    upd       = 1'b0;
    mispred   = 1'b0;
    if (bus.intr) begin
      redirect = 2'b10;
    end else if (bus.e_valid && bus.opcode_e == OP_SYSTEM && bus.fun3_e == 3'b000) begin
      redirect = 2'b10;
    end else if (bus.e_valid && bus.opcode_e == OP_BRANCH) begin
      upd     = 1'b1;
      mispred = (actual != bus.e_pred_taken);
      if (mispred) begin
        redirect  = 2'b01;
        redir_seq = ~actual;
      end
    end else if (bus.e_valid && (bus.opcode_e == OP_JAL || bus.opcode_e == OP_JALR)) begin
      redirect = 2'b01;
    end
  end

  assign bus.redirect  = redirect;
  assign bus.redir_seq = redir_seq;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= CTR_INIT;
    end else if (upd) begin
      if (actual && bht[e_idx] != 2'b11)
        bht[e_idx] <= bht[e_idx] + 2'd1;
      else if (!actual && bht[e_idx] != 2'b00)
        bht[e_idx] <= bht[e_idx] - 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else if (upd) begin
      if (br_cnt_q != '1) br_cnt_q <= br_cnt_q + 32'd1;
      if (mispred && mis_cnt_q != '1) mis_cnt_q <= mis_cnt_q + 32'd1;
    end
  end

  assign bus.br_cnt  = br_cnt_q;
  assign bus.mis_cnt = mis_cnt_q;

endmodule

// File: doc/branch_predict_unit.md
BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 Parameter XLEN, default 32, datapath width of operands and PCs.
REQ-002 Parameter BHT_DEPTH, default 64, number of 2-bit counters; SHALL be a power of two, at least 2.
REQ-003 Parameter CTR_INIT, default 2'b01, counter reset value (weakly not-taken).
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset, asynchronous and active-high.
REQ-006 f_pc  in  XLEN  fetch-stage PC used for prediction lookup.
REQ-007 pred_taken  out  1  fetch-stage direction prediction, combinational from table.
REQ-008 e_valid  in  1  execute-stage instruction valid.
REQ-009 e_pc  in  XLEN  execute-stage PC, used for update index.
REQ-010 opcode_e  in  7  execute-stage opcode; fun3_e  in  3  execute-stage funct3.
REQ-011 fwd_a, fwd_b  in  XLEN each  forwarded rs1/rs2 operands.
REQ-012 e_pred_taken  in  1  prediction carried down the pipe with the execute instruction.
REQ-013 intr  in  1  external interrupt request.
REQ-014 redirect  out  2  00 none, 01 branch/jump redirect, 10 trap redirect.
REQ-015 redir_seq  out  1  when redirect=01: 1 = fall-through (e_pc+4), 0 = computed target.
REQ-016 br_cnt, mis_cnt  out  32 each  resolved-branch and mispredict statistics.

Function
REQ-017 Index SHALL be pc[log2(BHT_DEPTH)+1 : 2]; f_pc for lookup, e_pc for update.
REQ-018 pred_taken SHALL equal bit 1 of the indexed counter.
REQ-019 Branch (opcode 1100011) actual outcome: fun3 000 A==B, 001 A!=B, 100 signed A<B, 101 signed A>=B, 110 unsigned A<B, 111 unsigned A>=B; 010/011 never taken.
REQ-020 Priority, highest first: intr -> redirect=10; e_valid and opcode_e=1110011 with fun3_e=000 -> redirect=10; e_valid branch -> mispredict path; e_valid JAL (1101111) or JALR (1100111) -> redirect=01, redir_seq=0; otherwise 00.
REQ-021 A branch with actual != e_pred_taken SHALL give redirect=01, with redir_seq=1 if actual not-taken and 0 if taken; actual == e_pred_taken SHALL give redirect=00.
REQ-022 redirect and redir_seq SHALL be combinational, zero-latency outputs; redir_seq SHALL be 0 whenever redirect!=01.
REQ-023 On a clock edge with an e_valid branch and no trap (redirect!=10), the indexed counter SHALL move +1 on taken, -1 on not-taken, saturating at 00 and 11.
REQ-024 JAL, JALR, system, and trapped instructions SHALL NOT modify the table.
REQ-025 Same-cycle lookup and update of one index: pred_taken SHALL reflect the pre-update value; there is no bypass.
REQ-026 br_cnt SHALL increment on each table update; mis_cnt SHALL increment on each update whose branch was mispredicted.
REQ-027 Both statistics counters SHALL saturate at 32'hFFFFFFFF, with no wrap-around.
REQ-028 e_valid=0 SHALL suppress all Execute-side effects except the intr trap.

Reset
REQ-029 While rst=1, all BHT counters SHALL hold CTR_INIT, br_cnt=0 and mis_cnt=0, independent of clk.
REQ-030 While rst=1, pred_taken SHALL read CTR_INIT[1].
REQ-031 redirect and redir_seq SHALL remain combinational during reset and follow REQ-020 to REQ-022.
REQ-032 Reset asserted mid-stream SHALL discard any update pending on that edge.

Verification
REQ-033 Training: after reset, BEQ with A=B=5 at e_pc 0x40, e_pred_taken=0 -> redirect=01, redir_seq=0, mis_cnt=1; next cycle f_pc=0x40 -> pred_taken=1 (counter 10).
REQ-034 Saturation: four taken BEQ at 0x40 -> counter 11; one not-taken BNE with A=B, e_pred_taken=1 -> redirect=01, redir_seq=1, counter 10, pred_taken still 1.
REQ-035 Compare semantics: A=0xFFFFFFFF, B=1 -> BLT taken, BLTU not taken, BGE not taken, BGEU taken; A=B -> BGE and BGEU taken.
REQ-036 Priority: intr=1 with a mispredicted branch in Execute -> redirect=10, no table update, br_cnt unchanged; ECALL (1110011, 000) alone -> redirect=10.
REQ-037 Aliasing and collision: with BHT_DEPTH=64, PCs 0x40 and 0x140 share one counter; same-cycle lookup and update of it returns the old value.
REQ-038 Reset and counters: rst pulse mid-training -> pred_taken=0 and statistics 0 immediately; br_cnt forced near max -> holds at 0xFFFFFFFF.
